// File: rtl/ram_access_arbiter_if.sv
// Requester-side bundle of the shared-RAM arbiter: packed per-requester requests in,
// one-hot grant / read-return pulses and the shared read data out.
interface ram_access_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 8,
  parameter int DW      = 8
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rvalid;
  logic [DW-1:0]         rdata;
  logic                  busy;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, rvalid, rdata, busy
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, rvalid, rdata, busy
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sequencing NUM_REQ requesters onto one single-port RAM,
// inserting a one-cycle bus turnaround between a read and a following write.
module ram_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 8,
  parameter int DW      = 8
) (
  input  logic                clk,
  input  logic                rst,
  ram_access_arbiter_if.slave bus,
  output logic                ram_ce,
  output logic                ram_we,
  output logic [AW-1:0]       ram_addr,
  inout  wire  [DW-1:0]       ram_data
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;
  typedef enum logic [1:0] {ACT_IDLE, ACT_LOAD, ACT_TURN} action_t;

  state_t        state;
  action_t       action;
  logic [IW-1:0] ptr;
  logic [IW-1:0] cur_idx;
  logic [IW-1:0] pend_idx;
  logic [DW-1:0] wdata_q;

  logic [NUM_REQ-1:0] cand;
  logic               found;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      load_idx;
  logic               ld_we;
  logic [AW-1:0]      ld_addr;
  logic [DW-1:0]      ld_wdata;
  logic [NUM_REQ-1:0] ld_gnt;

  // The RAM drives the bus only for reads, so the write register owns it exactly when ce&we.
  assign ram_data = (ram_ce && ram_we) ? wdata_q : {DW{1'bz}};
  assign bus.busy = (state != IDLE);

  // gnt is nonzero only during ACCESS, so it masks exactly the requester on the RAM now.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cand    = bus.req & ~bus.gnt;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && cand[(int'(ptr) + k) % NUM_REQ]) begin
        found   = 1'b1;
        win_idx = IW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    load_idx = (state == TURN) ? pend_idx : win_idx;
    ld_we    = bus.req_we[load_idx];
    ld_addr  = bus.req_addr[int'(load_idx)*AW +: AW];
    ld_wdata = bus.req_wdata[int'(load_idx)*DW +: DW];
    ld_gnt   = NUM_REQ'(1) << load_idx;
  end

  always_comb begin
    action = ACT_IDLE;
    unique case (state)
      IDLE:    if (found) action = ACT_LOAD;
      ACCESS:  if (found) action = (!ram_we && ld_we) ? ACT_TURN : ACT_LOAD;
      TURN:    action = ACT_LOAD;
      default: action = ACT_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cur_idx    <= '0;
      pend_idx   <= '0;
      wdata_q    <= '0;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      bus.gnt    <= '0;
      bus.rvalid <= '0;
      bus.rdata  <= '0;
    end else begin
      bus.gnt    <= '0;
      bus.rvalid <= '0;

      if (state == ACCESS) begin
        if (!ram_we) begin
          bus.rvalid <= bus.gnt;
          bus.rdata  <= ram_data;
        end
        ptr <= (cur_idx == IW'(NUM_REQ - 1)) ? '0 : cur_idx + IW'(1);
      end

      unique case (action)
        ACT_LOAD: begin
          state    <= ACCESS;
          ram_ce   <= 1'b1;
          ram_we   <= ld_we;
          ram_addr <= ld_addr;
          wdata_q  <= ld_wdata;
          cur_idx  <= load_idx;
          bus.gnt  <= ld_gnt;
        end
        ACT_TURN: begin
          state    <= TURN;
          ram_ce   <= 1'b0;
          ram_we   <= 1'b0;
          pend_idx <= win_idx;
        end
        default: begin
          state  <= IDLE;
          ram_ce <= 1'b0;
          ram_we <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural single-port RAM on the shared bus.
module tb_ram_access_arbiter;
  logic       clk;
  logic       rst;
  logic       ram_ce;
  logic       ram_we;
  logic [7:0] ram_addr;
  wire  [7:0] ram_data;
  logic       probe_en;
  logic [7:0] probe_val;
  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_fail   = 0;

  ram_access_arbiter_if #(.NUM_REQ(4), .AW(8), .DW(8)) rif ();

  ram_access_arbiter #(.NUM_REQ(4), .AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst), .bus(rif),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  // RAM model: combinational read, clocked write.
  assign ram_data = (ram_ce && !ram_we) ? mem[ram_addr] : 8'hzz;
  assign ram_data = probe_en ? probe_val : 8'hzz;
  always @(posedge clk) if (ram_ce && ram_we) mem[ram_addr] <= ram_data;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int idx, input logic we, input logic [7:0] a, input logic [7:0] d);
    rif.req_we[idx]          = we;
    rif.req_addr[idx*8 +: 8]  = a;
    rif.req_wdata[idx*8 +: 8] = d;
    rif.req[idx]             = 1'b1;
  endtask

  task automatic write_one(input int idx, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    post(idx, 1'b1, a, d);
    do begin tick(); n++; end while (!rif.gnt[idx] && n < 8);
    n_checks++;
    if (rif.gnt[idx] !== 1'b1) begin n_fail++; $display("FAIL write_one_gnt: req %0d got gnt=%b, required grant", idx, rif.gnt); end
    rif.req[idx] = 1'b0;
    tick();
  endtask

  task automatic read_one(input int idx, input logic [7:0] a, output logic [7:0] d);
    int n = 0;
    post(idx, 1'b0, a, 8'h00);
    do begin tick(); n++; end while (!rif.gnt[idx] && n < 8);
    n_checks++;
    if (rif.gnt[idx] !== 1'b1) begin n_fail++; $display("FAIL read_one_gnt: req %0d got gnt=%b, required grant", idx, rif.gnt); end
    rif.req[idx] = 1'b0;
    tick();
    n_checks++;
    if (rif.rvalid !== 4'(1 << idx)) begin n_fail++; $display("FAIL read_one_rvalid: got %b required %b", rif.rvalid, 4'(1 << idx)); end
    d = rif.rdata;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    rif.req = 4'($urandom); rif.req_we = 4'($urandom);
    rif.req_addr = 32'($urandom); rif.req_wdata = 32'($urandom);
    tick(); tick();
    n_checks++; if (rif.gnt !== 4'b0)    begin n_fail++; $display("FAIL reset_gnt: got %b required 0000", rif.gnt); end
    n_checks++; if (rif.rvalid !== 4'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b required 0000", rif.rvalid); end
    n_checks++; if (rif.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h required 00", rif.rdata); end
    n_checks++; if (ram_ce !== 1'b0)     begin n_fail++; $display("FAIL reset_ram_ce: got %b required 0", ram_ce); end
    n_checks++; if (ram_we !== 1'b0)     begin n_fail++; $display("FAIL reset_ram_we: got %b required 0", ram_we); end
    n_checks++; if (ram_addr !== 8'h00)  begin n_fail++; $display("FAIL reset_ram_addr: got %h required 00", ram_addr); end
    n_checks++; if (rif.busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b required 0", rif.busy); end
    probe_en = 1'b1; probe_val = 8'h00; #1;
    n_checks++; if (ram_data !== 8'h00)  begin n_fail++; $display("FAIL reset_bus_released: got %h required 00", ram_data); end
    probe_en = 1'b0;
    rif.req = '0; rst = 1'b1;
    tick();
    n_checks++; if (rif.busy !== 1'b0 || rif.gnt !== 4'b0) begin n_fail++; $display("FAIL reset_release_idle: busy=%b gnt=%b required 0/0000", rif.busy, rif.gnt); end
  endtask

  task automatic test_write_read;
    post(0, 1'b1, 8'h10, 8'hA5);
    tick();
    n_checks++; if (rif.gnt !== 4'b0001) begin n_fail++; $display("FAIL wr_gnt: got %b required 0001", rif.gnt); end
    n_checks++; if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h10) begin n_fail++; $display("FAIL wr_ram_pins: ce=%b we=%b addr=%h required 1/1/10", ram_ce, ram_we, ram_addr); end
    n_checks++; if (ram_data !== 8'hA5) begin n_fail++; $display("FAIL wr_ram_data: got %h required a5", ram_data); end
    n_checks++; if (rif.busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b required 1", rif.busy); end
    post(0, 1'b0, 8'h10, 8'h00);
    tick();
    n_checks++; if (rif.gnt !== 4'b0 || ram_ce !== 1'b0 || rif.busy !== 1'b0) begin n_fail++; $display("FAIL wr_masked_idle: gnt=%b ce=%b busy=%b required 0000/0/0", rif.gnt, ram_ce, rif.busy); end
    probe_en = 1'b1; probe_val = 8'h00; #1;
    n_checks++; if (ram_data !== 8'h00) begin n_fail++; $display("FAIL idle_bus_released: got %h required 00", ram_data); end
    probe_en = 1'b0;
    tick();
    n_checks++; if (rif.gnt !== 4'b0001 || ram_we !== 1'b0 || ram_addr !== 8'h10) begin n_fail++; $display("FAIL rd_gnt: gnt=%b we=%b addr=%h required 0001/0/10", rif.gnt, ram_we, ram_addr); end
    rif.req[0] = 1'b0;
    tick();
    n_checks++; if (rif.rvalid !== 4'b0001 || rif.rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_return: rvalid=%b rdata=%h required 0001/a5", rif.rvalid, rif.rdata); end
    tick();
    n_checks++; if (rif.rvalid !== 4'b0 || rif.rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_hold: rvalid=%b rdata=%h required 0000/a5", rif.rvalid, rif.rdata); end
  endtask

  task automatic test_round_robin;
    logic [7:0] data [4];
    data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33; data[3] = 8'h44;
    for (int i = 0; i < 4; i++) write_one(3, 8'h50 + 8'(i), data[i]);
    for (int i = 0; i < 4; i++) post(i, 1'b0, 8'h50 + 8'(i), 8'h00);
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (rif.gnt !== 4'(1 << (k % 4)) || ram_ce !== 1'b1 || ram_addr !== 8'h50 + 8'(k % 4)) begin
        n_fail++; $display("FAIL rr_grant_%0d: gnt=%b ce=%b addr=%h required %b/1/%h", k, rif.gnt, ram_ce, ram_addr, 4'(1 << (k % 4)), 8'h50 + 8'(k % 4));
      end
      if (k > 0) begin
        n_checks++;
        if (rif.rvalid !== 4'(1 << ((k - 1) % 4)) || rif.rdata !== data[(k - 1) % 4]) begin
          n_fail++; $display("FAIL rr_return_%0d: rvalid=%b rdata=%h required %b/%h", k, rif.rvalid, rif.rdata, 4'(1 << ((k - 1) % 4)), data[(k - 1) % 4]);
        end
      end
    end
    rif.req = '0;
    tick();
    n_checks++; if (rif.rvalid !== 4'b0010 || rif.rdata !== 8'h22 || rif.gnt !== 4'b0) begin n_fail++; $display("FAIL rr_last: rvalid=%b rdata=%h gnt=%b required 0010/22/0000", rif.rvalid, rif.rdata, rif.gnt); end
  endtask

  task automatic test_turnaround;
    logic [7:0] d;
    write_one(3, 8'h20, 8'h5C);
    post(1, 1'b0, 8'h20, 8'h00);
    tick();
    n_checks++; if (rif.gnt !== 4'b0010 || ram_we !== 1'b0 || ram_data !== 8'h5C) begin n_fail++; $display("FAIL ta_read: gnt=%b we=%b data=%h required 0010/0/5c", rif.gnt, ram_we, ram_data); end
    rif.req[1] = 1'b0;
    post(2, 1'b1, 8'h30, 8'h77);
    tick();
    n_checks++; if (rif.gnt !== 4'b0 || ram_ce !== 1'b0 || ram_we !== 1'b0 || rif.busy !== 1'b1) begin n_fail++; $display("FAIL ta_bubble: gnt=%b ce=%b we=%b busy=%b required 0000/0/0/1", rif.gnt, ram_ce, ram_we, rif.busy); end
    n_checks++; if (rif.rvalid !== 4'b0010 || rif.rdata !== 8'h5C) begin n_fail++; $display("FAIL ta_rdata: rvalid=%b rdata=%h required 0010/5c", rif.rvalid, rif.rdata); end
    probe_en = 1'b1; probe_val = 8'h00; #1;
    n_checks++; if (ram_data !== 8'h00) begin n_fail++; $display("FAIL ta_bus_released: got %h required 00", ram_data); end
    probe_en = 1'b0;
    tick();
    n_checks++; if (rif.gnt !== 4'b0100 || ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h30 || ram_data !== 8'h77) begin
      n_fail++; $display("FAIL ta_write: gnt=%b ce=%b we=%b addr=%h data=%h required 0100/1/1/30/77", rif.gnt, ram_ce, ram_we, ram_addr, ram_data);
    end
    rif.req[2] = 1'b0;
    tick();
    n_checks++; if (rif.busy !== 1'b0) begin n_fail++; $display("FAIL ta_idle: busy=%b required 0", rif.busy); end
    read_one(0, 8'h30, d);
    n_checks++; if (d !== 8'h77) begin n_fail++; $display("FAIL ta_readback: got %h required 77", d); end
  endtask

  task automatic test_masking;
    post(3, 1'b0, 8'h53, 8'h00);
    tick();
    n_checks++; if (rif.gnt !== 4'b1000) begin n_fail++; $display("FAIL mask_gnt1: got %b required 1000", rif.gnt); end
    tick();
    n_checks++; if (rif.gnt !== 4'b0 || ram_ce !== 1'b0 || rif.rvalid !== 4'b1000 || rif.rdata !== 8'h44) begin
      n_fail++; $display("FAIL mask_gap: gnt=%b ce=%b rvalid=%b rdata=%h required 0000/0/1000/44", rif.gnt, ram_ce, rif.rvalid, rif.rdata);
    end
    tick();
    n_checks++; if (rif.gnt !== 4'b1000) begin n_fail++; $display("FAIL mask_gnt2: got %b required 1000", rif.gnt); end
    tick();
    n_checks++; if (rif.gnt !== 4'b0) begin n_fail++; $display("FAIL mask_gap2: got %b required 0000", rif.gnt); end
    post(0, 1'b0, 8'h50, 8'h00);
    tick();
    n_checks++; if (rif.gnt !== 4'b0001) begin n_fail++; $display("FAIL mask_wrap: got %b required 0001", rif.gnt); end
    tick();
    n_checks++; if (rif.gnt !== 4'b1000 || rif.rvalid !== 4'b0001 || rif.rdata !== 8'h11) begin
      n_fail++; $display("FAIL mask_after_wrap: gnt=%b rvalid=%b rdata=%h required 1000/0001/11", rif.gnt, rif.rvalid, rif.rdata);
    end
    rif.req = '0;
    tick();
  endtask

  task automatic test_reset_mid_write;
    logic [7:0] d;
    write_one(0, 8'h40, 8'h12);
    post(0, 1'b1, 8'h40, 8'hEE);
    tick();
    n_checks++; if (rif.gnt !== 4'b0001 || ram_ce !== 1'b1 || ram_we !== 1'b1) begin n_fail++; $display("FAIL rst_mid_setup: gnt=%b ce=%b we=%b required 0001/1/1", rif.gnt, ram_ce, ram_we); end
    #1 rst = 1'b0;
    #1;
    n_checks++; if (ram_ce !== 1'b0 || rif.gnt !== 4'b0 || rif.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_abort: ce=%b gnt=%b busy=%b required 0/0000/0", ram_ce, rif.gnt, rif.busy); end
    rif.req = '0;
    tick();
    rst = 1'b1;
    tick();
    read_one(1, 8'h40, d);
    n_checks++; if (d !== 8'h12) begin n_fail++; $display("FAIL rst_mid_old_value: got %h required 12", d); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; probe_en = 1'b0; probe_val = 8'h00;
    rif.req = '0; rif.req_we = '0; rif.req_addr = '0; rif.req_wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_turnaround();
    test_masking();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
